aes_block_assembler: RTL and testbench



---
 rtl/aes_block_assembler.sv | 144 ++++++++++++++
 tb/tb_aes_block_assembler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_assembler.sv
// ============================================================================
// Module   : aes_block_assembler
// Function : Double-buffered word-to-block assembler for the cipher core.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_block_assembler #(
    parameter int WordW       = 32,
    parameter int NumWords    = 4,
    parameter bit ClearOnRead = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clr_i,
    input  logic                        wvalid_i,
    input  logic [WordW-1:0]            wdata_i,
    input  logic                        wlast_i,
    output logic                        wready_o,
    output logic                        bvalid_o,
    output logic [WordW*NumWords-1:0]   bdata_o,
    output logic [NumWords-1:0]         bmask_o,
    input  logic                        bready_i,
    output logic [$clog2(NumWords):0]   wcnt_o
);

    localparam int BlockW = WordW * NumWords;
    localparam int CntW   = $clog2(NumWords) + 1;

    logic                clr_q;
    logic [CntW-1:0]     cnt_q,       cnt_d;
    logic [BlockW-1:0]   col_data_q,  col_data_d;
    logic [NumWords-1:0] col_mask_q,  col_mask_d;
    logic                col_done_q,  col_done_d;
    logic                out_valid_q, out_valid_d;
    logic [BlockW-1:0]   out_data_q,  out_data_d;
    logic [NumWords-1:0] out_mask_q,  out_mask_d;

    logic                w_acc;
    logic                w_out_hs;
    logic                w_last_slot;
    logic                w_complete;
    logic                w_out_free;
    logic [BlockW-1:0]   w_blk_data;
    logic [NumWords-1:0] w_blk_mask;

    assign wready_o    = !clr_q && !col_done_q;
    assign bvalid_o    = !clr_q && out_valid_q;
    assign bdata_o     = out_data_q;
    assign bmask_o     = out_mask_q;
    assign wcnt_o      = cnt_q;

    assign w_acc       = wvalid_i && wready_o;
    assign w_out_hs    = bvalid_o && bready_i;
    assign w_last_slot = (cnt_q == CntW'(NumWords - 1));
    assign w_complete  = w_acc && (w_last_slot || wlast_i);
    assign w_out_free  = !out_valid_q || w_out_hs;

    // Collection block as it looks with the incoming word merged in.
    generate
        for (genvar k = 0; k < NumWords; k++) begin : g_slot
            logic w_hit;
            assign w_hit = w_acc && (cnt_q == CntW'(k));
            assign w_blk_data[k*WordW +: WordW] = w_hit ? wdata_i : col_data_q[k*WordW +: WordW];
            assign w_blk_mask[k]                = col_mask_q[k] | w_hit;
        end
    endgenerate

    always_comb begin
        cnt_d       = cnt_q;
        col_data_d  = col_data_q;
        col_mask_d  = col_mask_q;
        col_done_d  = col_done_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;

        if (clr_i) begin
            cnt_d       = '0;
            col_data_d  = '0;
            col_mask_d  = '0;
            col_done_d  = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_mask_d  = '0;
        end else if (col_done_q && w_out_hs) begin
            // Parked block moves up as the current one drains.
            out_valid_d = 1'b1;
            out_data_d  = col_data_q;
            out_mask_d  = col_mask_q;
            cnt_d       = '0;
            col_data_d  = '0;
            col_mask_d  = '0;
            col_done_d  = 1'b0;
        end else if (w_complete && w_out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = w_blk_data;
            out_mask_d  = w_blk_mask;
            cnt_d       = '0;
            col_data_d  = '0;
            col_mask_d  = '0;
        end else begin
            if (w_acc) begin
                cnt_d      = cnt_q + CntW'(1);
                col_data_d = w_blk_data;
                col_mask_d = w_blk_mask;
                col_done_d = w_complete;
            end
            if (w_out_hs) begin
                out_valid_d = 1'b0;
                if (ClearOnRead) begin
                    out_data_d = '0;
                    out_mask_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clr_q       <= 1'b1;
            cnt_q       <= '0;
            col_data_q  <= '0;
            col_mask_q  <= '0;
            col_done_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
        end else begin
            clr_q       <= clr_i;
            cnt_q       <= cnt_d;
            col_data_q  <= col_data_d;
            col_mask_q  <= col_mask_d;
            col_done_q  <= col_done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_block_assembler.sv
// ============================================================================
// Module   : tb_aes_block_assembler
// Function : Self-checking bench for aes_block_assembler (both ClearOnRead modes).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_aes_block_assembler;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clr_i;
    logic         wvalid_i;
    logic [31:0]  wdata_i;
    logic         wlast_i;
    logic         bready_i;

    logic         wready_c,  wready_h;
    logic         bvalid_c,  bvalid_h;
    logic [127:0] bdata_c,   bdata_h;
    logic [3:0]   bmask_c,   bmask_h;
    logic [2:0]   wcnt_c,    wcnt_h;

    int checks = 0;
    int errors = 0;
    int nblk   = 0;

    always #5 clk_i = ~clk_i;

    aes_block_assembler #(.WordW(32), .NumWords(4), .ClearOnRead(1'b1)) u_dut_cor (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wlast_i(wlast_i), .wready_o(wready_c),
        .bvalid_o(bvalid_c), .bdata_o(bdata_c), .bmask_o(bmask_c), .bready_i(bready_i),
        .wcnt_o(wcnt_c)
    );

    aes_block_assembler #(.WordW(32), .NumWords(4), .ClearOnRead(1'b0)) u_dut_hold (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wlast_i(wlast_i), .wready_o(wready_h),
        .bvalid_o(bvalid_h), .bdata_o(bdata_h), .bmask_o(bmask_h), .bready_i(bready_i),
        .wcnt_o(wcnt_h)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words waiting in collection as a queue, output block as a value.
    logic [31:0]  m_col[$];
    bit           m_clr     = 1'b1;
    bit           m_done    = 1'b0;
    bit           m_ov      = 1'b0;
    bit           m_cleared = 1'b0;
    logic [127:0] m_od      = '0;
    logic [3:0]   m_om      = '0;

    task automatic m_load_out();
        m_od = '0;
        m_om = '0;
        foreach (m_col[k]) begin
            m_od[k*32 +: 32] = m_col[k];
            m_om[k]          = 1'b1;
        end
        m_col.delete();
        m_ov      = 1'b1;
        m_cleared = 1'b0;
    endtask

    task automatic m_flush();
        m_col.delete();
        m_done    = 1'b0;
        m_ov      = 1'b0;
        m_cleared = 1'b0;
        m_od      = '0;
        m_om      = '0;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_flush();
            m_clr = 1'b1;
        end else if (clr_i) begin
            m_flush();
            m_clr = 1'b1;
        end else begin
            bit acc, hs, cmp;
            acc   = wvalid_i && !m_clr && !m_done;
            hs    = !m_clr && m_ov && bready_i;
            cmp   = 1'b0;
            m_clr = 1'b0;
            if (acc) begin
                m_col.push_back(wdata_i);
                cmp = (m_col.size() == 4) || wlast_i;
            end
            if (m_done && hs) begin
                m_load_out();
                m_done = 1'b0;
            end else if (cmp && (!m_ov || hs)) begin
                m_load_out();
            end else begin
                if (cmp) m_done = 1'b1;
                if (hs) begin
                    m_ov      = 1'b0;
                    m_cleared = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        logic         e_wr, e_bv;
        logic [2:0]   e_cnt;
        e_wr  = !m_clr && !m_done;
        e_bv  = !m_clr && m_ov;
        e_cnt = 3'(m_col.size());
        chk("cor_wready", wready_c, e_wr);
        chk("cor_bvalid", bvalid_c, e_bv);
        chk("cor_bdata",  bdata_c,  m_cleared ? 128'h0 : m_od);
        chk("cor_bmask",  bmask_c,  m_cleared ? 4'h0 : m_om);
        chk("cor_wcnt",   wcnt_c,   e_cnt);
        chk("hold_wready", wready_h, e_wr);
        chk("hold_bvalid", bvalid_h, e_bv);
        chk("hold_bdata",  bdata_h,  m_od);
        chk("hold_bmask",  bmask_h,  m_om);
        chk("hold_wcnt",   wcnt_h,   e_cnt);
        if (bvalid_c && bready_i) nblk++;
    end

    task automatic step(input logic v, input logic [31:0] d, input logic l,
                        input logic br, input logic c);
        wvalid_i = v;
        wdata_i  = d;
        wlast_i  = l;
        bready_i = br;
        clr_i    = c;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int nb;
        rst_ni   = 1'b1;
        clr_i    = 1'b0;
        wvalid_i = 1'b0;
        wdata_i  = '0;
        wlast_i  = 1'b0;
        bready_i = 1'b0;
        #1 rst_ni = 1'b0;
        #2;
        chk("rst_wready", wready_c, 1'b0);
        chk("rst_wcnt",   wcnt_c,   3'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("ready_after_clr", wready_c, 1'b1);

        // Basic four-word block
        for (int i = 0; i < 4; i++) begin
            chk("wcnt_seq", wcnt_c, 3'(i));
            step(1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 0, 1, 0);
        end
        chk("t1_bvalid", bvalid_c, 1'b1);
        chk("t1_bdata",  bdata_c,  128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("t1_bmask",  bmask_c,  4'b1111);
        chk("t1_wcnt",   wcnt_c,   3'd0);
        step(0, 0, 0, 1, 0);
        chk("cor_cleared_data", bdata_c, 128'h0);
        chk("cor_cleared_mask", bmask_c, 4'h0);
        chk("hold_kept_data",   bdata_h, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("hold_kept_mask",   bmask_h, 4'b1111);

        // Three back-to-back blocks, last word of block 3 also carries wlast
        nb = nblk;
        for (int i = 0; i < 12; i++) step(1, 32'h1000_0000 + i, i == 11, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("t2_blocks", 128'(nblk - nb), 128'd3);

        // Backpressure: block0 on output, block1 parked
        for (int i = 0; i < 8; i++) step(1, 32'h2000_0000 + i, 0, 0, 0);
        chk("t3_wready", wready_c, 1'b0);
        chk("t3_wcnt",   wcnt_c,   3'd4);
        chk("t3_blk0",   bdata_c,  {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000});
        step(0, 0, 0, 1, 0);
        chk("t3_bvalid", bvalid_c, 1'b1);
        chk("t3_blk1",   bdata_c,  {32'h2000_0007, 32'h2000_0006, 32'h2000_0005, 32'h2000_0004});
        chk("t3_ready",  wready_c, 1'b1);
        step(0, 0, 0, 1, 0);
        chk("t3_drained", bvalid_c, 1'b0);

        // Early termination with zero padding
        step(1, 32'hAAAA_0001, 0, 1, 0);
        step(1, 32'hAAAA_0002, 1, 1, 0);
        chk("t4_bdata", bdata_c, {64'h0, 32'hAAAA_0002, 32'hAAAA_0001});
        chk("t4_bmask", bmask_c, 4'b0011);
        chk("t4_wcnt",  wcnt_c,  3'd0);
        step(1, 32'hBBBB_0001, 1, 1, 0);
        chk("t4_next_data", bdata_c, {96'h0, 32'hBBBB_0001});
        chk("t4_next_mask", bmask_c, 4'b0001);
        step(0, 0, 0, 1, 0);

        // Flush with a block pending and a partial block collected
        for (int i = 0; i < 4; i++) step(1, 32'h3000_0000 + i, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 32'h3100_0000 + i, 0, 0, 0);
        chk("t5_wcnt_pre", wcnt_c, 3'd2);
        step(1, 32'hDEAD_BEEF, 0, 1, 1);
        chk("t5_bvalid", bvalid_c, 1'b0);
        chk("t5_wcnt",   wcnt_c,   3'd0);
        chk("t5_wready", wready_c, 1'b0);
        chk("t5_hold_data", bdata_h, 128'h0);
        step(0, 0, 0, 0, 0);
        chk("t5_ready_back", wready_c, 1'b1);
        for (int i = 0; i < 4; i++) step(1, 32'h4000_0000 + i, 0, 1, 0);
        chk("t5_fresh", bdata_c, {32'h4000_0003, 32'h4000_0002, 32'h4000_0001, 32'h4000_0000});
        chk("t5_mask",  bmask_c, 4'b1111);
        step(0, 0, 0, 1, 0);

        // Asynchronous reset mid-block
        step(1, 32'h5000_0000, 0, 1, 0);
        step(1, 32'h5000_0001, 0, 1, 0);
        wvalid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_wcnt",   wcnt_c,   3'd0);
        chk("t6_wready", wready_c, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h6000_0000 + i, i == 2, 1, 0);
        chk("t6_bdata", bdata_c, {32'h0, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000});
        chk("t6_bmask", bmask_c, 4'b0111);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
